counter_bank: RTL and testbench

Parametrised bank of independent up-counters sharing one clock and one asynchronous active-high reset. Each channel has a per-channel enable, synchronous load, programmable terminal value and a registered overflow flag. It is the generalised successor to the single 8-bit counters used across the design's top-level test modules, and is instantiated wherever several event or cycle counters with uniform reset behaviour are needed.

---
 rtl/counter_bank.sv | 91 +++++++++
 tb/tb_counter_bank.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// counter_bank: bank of CHANNELS independent WIDTH-bit up-counters sharing one
// clock and one asynchronous active-high reset.
//
// Build option: COUNTER_BANK_SATURATE_EN
//    defined   - a channel that is enabled at LIMIT holds at LIMIT
//    undefined - a channel that is enabled at LIMIT wraps to 0
//    OVF pulses for one cycle on every such event in both builds.
//
// Ports
//    CLK        clock, rising edge
//    RST        asynchronous reset, active high (counters -> RST_VALUE, OVF -> 0)
//    CLR        synchronous clear of all channels to RST_VALUE
//    EN         per-channel count enable
//    LOAD       per-channel synchronous load strobe
//    LOAD_DATA  load value shared by all channels, clamped to LIMIT
//    CNT        counter values, channel i at [i*WIDTH +: WIDTH]
//    OVF        per-channel registered overflow pulse
//    AT_LIMIT   per-channel flag, decoded from the counter register only
module counter_bank #(
   parameter int               WIDTH     = 8,
   parameter int               CHANNELS  = 4,
   parameter logic [WIDTH-1:0] RST_VALUE = '0,
   parameter logic [WIDTH-1:0] LIMIT     = {WIDTH{1'b1}}
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      CLR,
   input  logic [CHANNELS-1:0]       EN,
   input  logic [CHANNELS-1:0]       LOAD,
   input  logic [WIDTH-1:0]          LOAD_DATA,
   output logic [CHANNELS*WIDTH-1:0] CNT,
   output logic [CHANNELS-1:0]       OVF,
   output logic [CHANNELS-1:0]       AT_LIMIT
);

`ifdef COUNTER_BANK_SATURATE_EN
   localparam logic [WIDTH-1:0] OVF_NEXT = LIMIT;
`else
   localparam logic [WIDTH-1:0] OVF_NEXT = '0;
`endif

   logic [WIDTH-1:0]    cnt_q [CHANNELS];
   logic [WIDTH-1:0]    cnt_d [CHANNELS];
   logic [CHANNELS-1:0] ovf_q;
   logic [CHANNELS-1:0] ovf_d;
   logic [WIDTH-1:0]    load_val;

   // Loads above the terminal count clamp so a counter never sits above LIMIT.
   assign load_val = (LOAD_DATA > LIMIT) ? LIMIT : LOAD_DATA;

   always_comb begin
      ovf_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (CLR) begin
            cnt_d[i] = RST_VALUE;
         end else if (LOAD[i]) begin
            cnt_d[i] = load_val;
         end else if (EN[i]) begin
            if (cnt_q[i] == LIMIT) begin
               cnt_d[i] = OVF_NEXT;
               ovf_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= RST_VALUE;
         end
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         ovf_q <= ovf_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign CNT[g*WIDTH +: WIDTH] = cnt_q[g];
      assign AT_LIMIT[g]           = (cnt_q[g] == LIMIT);
   end

   assign OVF = ovf_q;

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank (WIDTH=8, CHANNELS=4, RST_VALUE=3, LIMIT=9).
// The stimulus process pushes hand-computed expectations into a queue; a
// monitor pops one entry just after each rising edge and compares.
module tb_counter_bank;

   logic        CLK;
   logic        RST;
   logic        CLR;
   logic [3:0]  EN;
   logic [3:0]  LOAD;
   logic [7:0]  LOAD_DATA;
   logic [31:0] CNT;
   logic [3:0]  OVF;
   logic [3:0]  AT_LIMIT;

   counter_bank #(
      .WIDTH(8), .CHANNELS(4), .RST_VALUE(8'd3), .LIMIT(8'd9)
   ) dut (
      .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .LOAD(LOAD),
      .LOAD_DATA(LOAD_DATA), .CNT(CNT), .OVF(OVF), .AT_LIMIT(AT_LIMIT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      int          id;
      logic [31:0] cnt;
      logic [3:0]  ovf;
      logic [3:0]  atl;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic check(input exp_t e);
      vectors++;
      if (CNT !== e.cnt || OVF !== e.ovf || AT_LIMIT !== e.atl) begin
         miscompares++;
         $display("FAIL vec%0d: got CNT=%h OVF=%b AT_LIMIT=%b, expected CNT=%h OVF=%b AT_LIMIT=%b",
                  e.id, CNT, OVF, AT_LIMIT, e.cnt, e.ovf, e.atl);
      end
   endtask

   // Called at a falling edge: drive inputs, queue the state expected after
   // the next rising edge, then advance to the following falling edge.
   task automatic step(input int id, input logic clr, input logic [3:0] en,
                       input logic [3:0] load, input logic [7:0] ld,
                       input logic [31:0] ecnt, input logic [3:0] eovf,
                       input logic [3:0] eatl);
      exp_t e;
      CLR = clr; EN = en; LOAD = load; LOAD_DATA = ld;
      e.id = id; e.cnt = ecnt; e.ovf = eovf; e.atl = eatl;
      sb.push_back(e);
      @(negedge CLK);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e);
         end
      end
   end

   // Channel 0 counting from 0 with EN for 12 cycles.
`ifdef COUNTER_BANK_SATURATE_EN
   int seq_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
   bit seq_ovf [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
   bit seq_atl [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
`else
   int seq_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
   bit seq_ovf [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
   bit seq_atl [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
`endif

   initial begin
      exp_t e;
      RST = 1'b1; CLR = 1'b0; EN = '0; LOAD = '0; LOAD_DATA = '0;

      // Reset value visible between edges while RST is high.
      #12;
      e = '{id: 1, cnt: 32'h03030303, ovf: 4'b0000, atl: 4'b0000};
      check(e);
      @(negedge CLK);
      RST = 1'b0;

      // Load every channel with 0.
      step(2, 1'b0, 4'b0000, 4'b1111, 8'd0, 32'h00000000, 4'b0000, 4'b0000);

      // Channel 0 runs through LIMIT.
      for (int k = 0; k < 12; k++) begin
         step(10 + k, 1'b0, 4'b0001, 4'b0000, 8'd0,
              {24'h0, 8'(seq_cnt[k])}, {3'b000, seq_ovf[k]}, {3'b000, seq_atl[k]});
      end

      // All channels to 5, then clamped load on ch1 wins over EN.
      step(30, 1'b0, 4'b0000, 4'b1111, 8'd5, 32'h05050505, 4'b0000, 4'b0000);
      step(31, 1'b0, 4'b1111, 4'b0010, 8'd200, 32'h06060906, 4'b0000, 4'b0010);

      // Ch1 at LIMIT overflows while ch3 counts; ch0/ch2 hold.
`ifdef COUNTER_BANK_SATURATE_EN
      step(32, 1'b0, 4'b1010, 4'b0000, 8'd0, 32'h07060906, 4'b0010, 4'b0010);
      step(33, 1'b0, 4'b0000, 4'b0000, 8'd0, 32'h07060906, 4'b0000, 4'b0010);
`else
      step(32, 1'b0, 4'b1010, 4'b0000, 8'd0, 32'h07060006, 4'b0010, 4'b0000);
      step(33, 1'b0, 4'b0000, 4'b0000, 8'd0, 32'h07060006, 4'b0000, 4'b0000);
`endif

      // CLR beats LOAD and EN.
      step(34, 1'b1, 4'b1111, 4'b1111, 8'd8, 32'h03030303, 4'b0000, 4'b0000);
      // Exact-LIMIT load on ch0, below-LIMIT load on ch2.
      step(35, 1'b0, 4'b0000, 4'b0001, 8'd9, 32'h03030309, 4'b0000, 4'b0001);
      step(36, 1'b0, 4'b0000, 4'b0100, 8'd7, 32'h03070309, 4'b0000, 4'b0001);

      // Reset mid-count with ch2 at 7 and EN high.
      EN = 4'b0100;
      #2;
      RST = 1'b1;
      #1;
      e = '{id: 37, cnt: 32'h03030303, ovf: 4'b0000, atl: 4'b0000};
      check(e);
      @(negedge CLK);
      e = '{id: 38, cnt: 32'h03030303, ovf: 4'b0000, atl: 4'b0000};
      check(e);
      RST = 1'b0;
      step(39, 1'b0, 4'b0100, 4'b0000, 8'd0, 32'h03040303, 4'b0000, 4'b0000);
      step(40, 1'b0, 4'b0100, 4'b0000, 8'd0, 32'h03050303, 4'b0000, 4'b0000);

      EN = '0;
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge CLK);
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
